// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with 64-bit cycle/instret counters,
// NUM_IRQ level-sensitive external interrupts and prioritised trap entry/exit.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   r_en, w_en, op, in        CSR access (op[1:0]: 01 write, 10 set, 11 clear)
//   csr_addr, out, illegal    CSR address, combinational read data, bad access
//   pc, ecall, ebreak, mret   current PC and decoded system instructions
//   is_misaligned, is_misalignment_store, mem_addr   misaligned access info
//   instr_retire, int_window  retire strobe, interrupt acceptance window
//   irq                       external interrupt lines
//   trap_taken/trap_vector    registered trap redirect
//   mret_taken/mret_pc        registered mret redirect
//   irq_pending               (mip & mie) != 0
module csr_trap_unit #(
    parameter int          NUM_IRQ   = 4,
    parameter logic [31:0] HART_ID   = 32'h0,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL  = 32'h4000_0100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               r_en,
    input  logic               w_en,
    input  logic [2:0]         op,
    input  logic [31:0]        in,
    input  logic [11:0]        csr_addr,
    output logic [31:0]        out,
    output logic               illegal,
    input  logic [31:0]        pc,
    input  logic               ecall,
    input  logic               ebreak,
    input  logic               mret,
    input  logic               is_misaligned,
    input  logic               is_misalignment_store,
    input  logic [31:0]        mem_addr,
    input  logic               instr_retire,
    input  logic               int_window,
    input  logic [NUM_IRQ-1:0] irq,
    output logic               trap_taken,
    output logic [31:0]        trap_vector,
    output logic               mret_taken,
    output logic [31:0]        mret_pc,
    output logic               irq_pending
);
    localparam logic [11:0] A_MSTATUS  = 12'h300, A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304, A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340, A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342, A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344, A_MHARTID  = 12'hF14;
    localparam logic [11:0] A_MCYCLE   = 12'hB00, A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTRET = 12'hB02, A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE    = 12'hC00, A_CYCLEH   = 12'hC80;
    localparam logic [11:0] A_INSTRET  = 12'hC02, A_INSTRETH = 12'hC82;

    logic               st_mie, st_mpie;
    logic [NUM_IRQ-1:0] mie_q, mip_q;
    logic [31:0]        mtvec, mscratch, mepc, mcause, mtval;
    logic [63:0]        mcycle, minstret;

    logic [31:0] raw, wdata, base;
    logic        impl, csr_we, exc, irq_take;
    logic [NUM_IRQ-1:0] pend;
    logic [4:0]  irq_idx, irq_code;

    // Raw read mux; also feeds the set/clear read-modify-write.
    always_comb begin
        raw  = '0;
        impl = 1'b1;
        case (csr_addr)
            A_MSTATUS:  raw = 32'h1800 | (32'(st_mpie) << 7) | (32'(st_mie) << 3);
            A_MISA:     raw = MISA_VAL;
            A_MIE:      raw[16 +: NUM_IRQ] = mie_q;
            A_MTVEC:    raw = mtvec;
            A_MSCRATCH: raw = mscratch;
            A_MEPC:     raw = {mepc[31:2], 2'b00};
            A_MCAUSE:   raw = mcause;
            A_MTVAL:    raw = mtval;
            A_MIP:      raw[16 +: NUM_IRQ] = mip_q;
            A_MHARTID:  raw = HART_ID;
            A_MCYCLE,   A_CYCLE:    raw = mcycle[31:0];
            A_MCYCLEH,  A_CYCLEH:   raw = mcycle[63:32];
            A_MINSTRET, A_INSTRET:  raw = minstret[31:0];
            A_MINSTRETH, A_INSTRETH: raw = minstret[63:32];
            default:    impl = 1'b0;
        endcase
    end

    assign out     = r_en ? raw : 32'h0;
    assign illegal = ((r_en | w_en) & ~impl) | (w_en & (csr_addr[11:10] == 2'b11));

    always_comb begin
        case (op[1:0])
            2'b01:   wdata = in;
            2'b10:   wdata = raw | in;
            2'b11:   wdata = raw & ~in;
            default: wdata = raw;
        endcase
    end

    // Lowest-numbered pending line wins.
    assign pend        = mip_q & mie_q;
    assign irq_pending = |pend;
    always_comb begin
        irq_idx = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--)
            if (pend[k]) irq_idx = 5'(k);
    end
    assign irq_code = 5'd16 + irq_idx;
    assign base     = {mtvec[31:2], 2'b00};

    assign exc      = is_misaligned | ecall | ebreak;
    assign irq_take = ~exc & ~mret & int_window & st_mie & irq_pending;
    assign csr_we   = w_en & (op[1:0] != 2'b00) & ~illegal & ~exc & ~mret & ~irq_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_mie <= 1'b0; st_mpie <= 1'b0;
            mie_q <= '0; mip_q <= '0;
            mtvec <= MTVEC_RST; mscratch <= '0; mepc <= '0; mcause <= '0; mtval <= '0;
            trap_taken <= 1'b0; trap_vector <= '0;
            mret_taken <= 1'b0; mret_pc <= '0;
        end else begin
            mip_q      <= irq;
            trap_taken <= 1'b0;
            mret_taken <= 1'b0;
            if (exc) begin
                mepc    <= pc;
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
                trap_taken  <= 1'b1;
                trap_vector <= base;
                if (is_misaligned) begin
                    mtval  <= mem_addr;
                    mcause <= is_misalignment_store ? 32'd6 : 32'd4;
                end else begin
                    mtval  <= '0;
                    mcause <= ecall ? 32'd11 : 32'd3;
                end
            end else if (mret) begin
                st_mie     <= st_mpie;
                st_mpie    <= 1'b1;
                mret_taken <= 1'b1;
                mret_pc    <= {mepc[31:2], 2'b00};
            end else if (irq_take) begin
                mepc    <= pc;
                mtval   <= '0;
                mcause  <= 32'h8000_0000 | 32'(irq_code);
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
                trap_taken  <= 1'b1;
                trap_vector <= (mtvec[1:0] == 2'b01) ? base + {25'b0, irq_code, 2'b00} : base;
            end else if (csr_we) begin
                case (csr_addr)
                    A_MSTATUS:  begin st_mie <= wdata[3]; st_mpie <= wdata[7]; end
                    A_MIE:      mie_q <= wdata[16 +: NUM_IRQ];
                    // Modes 2/3 are reserved and collapse to direct.
                    A_MTVEC:    mtvec <= {wdata[31:2], wdata[1] ? 2'b00 : wdata[1:0]};
                    A_MSCRATCH: mscratch <= wdata;
                    A_MEPC:     mepc <= wdata;
                    A_MCAUSE:   mcause <= wdata;
                    A_MTVAL:    mtval <= wdata;
                    default: ;
                endcase
            end
        end
    end

    // A write to either half replaces it and freezes the counter for that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (csr_we && csr_addr == A_MCYCLE)       mcycle[31:0]  <= wdata;
            else if (csr_we && csr_addr == A_MCYCLEH) mcycle[63:32] <= wdata;
            else                                      mcycle <= mcycle + 64'd1;

            if (csr_we && csr_addr == A_MINSTRET)       minstret[31:0]  <= wdata;
            else if (csr_we && csr_addr == A_MINSTRETH) minstret[63:32] <= wdata;
            else if (instr_retire)                      minstret <= minstret + 64'd1;
        end
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed-vector bench for csr_trap_unit.
module tb_csr_trap_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        r_en = 0, w_en = 0;
    logic [2:0]  op = 3'b000;
    logic [31:0] din = 0, out;
    logic [11:0] csr_addr = 0;
    logic        illegal;
    logic [31:0] pc = 0, mem_addr = 0;
    logic        ecall = 0, ebreak = 0, mret = 0;
    logic        is_misaligned = 0, is_misalignment_store = 0;
    logic        instr_retire = 0, int_window = 0;
    logic [3:0]  irq = 0;
    logic        trap_taken, mret_taken, irq_pending;
    logic [31:0] trap_vector, mret_pc;

    int n_chk = 0, n_err = 0;

    csr_trap_unit dut (
        .clk(clk), .rst(rst), .r_en(r_en), .w_en(w_en), .op(op), .in(din),
        .csr_addr(csr_addr), .out(out), .illegal(illegal), .pc(pc),
        .ecall(ecall), .ebreak(ebreak), .mret(mret),
        .is_misaligned(is_misaligned), .is_misalignment_store(is_misalignment_store),
        .mem_addr(mem_addr), .instr_retire(instr_retire), .int_window(int_window),
        .irq(irq), .trap_taken(trap_taken), .trap_vector(trap_vector),
        .mret_taken(mret_taken), .mret_pc(mret_pc), .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] v);
        w_en = 1; op = 3'b001; csr_addr = a; din = v;
        tick();
        w_en = 0; op = 3'b000;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        r_en = 1; csr_addr = a; #1;
        chk(tag, out, exp);
        r_en = 0;
    endtask

    initial begin
        tick(); tick();
        rst = 0;
        chk("rst_trap_taken", {31'b0, trap_taken}, 0);
        chk("rst_mret_taken", {31'b0, mret_taken}, 0);
        rd("misa", 12'h301, 32'h4000_0100);
        chk("misa_illegal", {31'b0, illegal}, 0);
        rd("mhartid", 12'hF14, 32'h0);
        rd("mtvec_rst", 12'h305, 32'h0);
        rd("mstatus_rst", 12'h300, 32'h1800);
        r_en = 1; csr_addr = 12'h7C0; #1;
        chk("unimpl_out", out, 0);
        chk("unimpl_illegal", {31'b0, illegal}, 1);
        r_en = 0;

        // WARL mtvec and mepc low bits
        csr_wr(12'h305, 32'h0000_0102);
        rd("mtvec_warl", 12'h305, 32'h0000_0100);
        csr_wr(12'h341, 32'h0000_1237);
        rd("mepc_lsb", 12'h341, 32'h0000_1234);
        // set / clear
        csr_wr(12'h340, 32'h0000_00F0);
        w_en = 1; op = 3'b010; csr_addr = 12'h340; din = 32'h0000_000F; tick();
        w_en = 1; op = 3'b011; csr_addr = 12'h340; din = 32'h0000_0030; tick();
        w_en = 0; op = 3'b000;
        rd("mscratch_rmw", 12'h340, 32'h0000_00CF);

        // ecall in direct mode with MIE=1
        csr_wr(12'h305, 32'h0000_0100);
        csr_wr(12'h300, 32'h0000_0008);
        pc = 32'h2C; ecall = 1; tick(); ecall = 0;
        chk("ecall_taken", {31'b0, trap_taken}, 1);
        chk("ecall_vec", trap_vector, 32'h100);
        rd("ecall_mepc", 12'h341, 32'h2C);
        rd("ecall_mcause", 12'h342, 32'd11);
        rd("ecall_mstatus", 12'h300, 32'h1880);
        tick();
        chk("trap_pulse", {31'b0, trap_taken}, 0);

        // vectored interrupt on irq[1], then mret
        csr_wr(12'h305, 32'h0000_0101);
        csr_wr(12'h304, 32'h0002_0000);
        csr_wr(12'h300, 32'h0000_0008);
        pc = 32'h40; irq = 4'b0010; int_window = 1;
        tick();
        chk("irq_pending", {31'b0, irq_pending}, 1);
        tick();
        int_window = 0; irq = 0;
        chk("irq_taken", {31'b0, trap_taken}, 1);
        chk("irq_vec", trap_vector, 32'h144);
        rd("irq_mcause", 12'h342, 32'h8000_0011);
        rd("irq_mepc", 12'h341, 32'h40);
        mret = 1; tick(); mret = 0;
        chk("mret_taken", {31'b0, mret_taken}, 1);
        chk("mret_pc", mret_pc, 32'h40);
        rd("mret_mstatus", 12'h300, 32'h1888);

        // misaligned store beats ecall
        pc = 32'h80; mem_addr = 32'h1003; is_misaligned = 1; is_misalignment_store = 1; ecall = 1;
        tick();
        is_misaligned = 0; is_misalignment_store = 0; ecall = 0;
        chk("mis_taken", {31'b0, trap_taken}, 1);
        chk("mis_vec", trap_vector, 32'h100);
        rd("mis_mcause", 12'h342, 32'd6);
        rd("mis_mtval", 12'h343, 32'h1003);

        // 64-bit carry, and read-only alias write
        csr_wr(12'hB00, 32'hFFFF_FFFF);
        csr_wr(12'hB80, 32'h0);
        tick();
        rd("mcycle_lo", 12'hB00, 32'h0);
        rd("mcycle_hi", 12'hB80, 32'h1);
        w_en = 1; op = 3'b001; csr_addr = 12'hC00; din = 32'h55; #1;
        chk("cycle_wr_illegal", {31'b0, illegal}, 1);
        tick(); w_en = 0; op = 3'b000;
        rd("cycle_after_lo", 12'hB00, 32'h1);
        rd("cycle_after_hi", 12'hC80, 32'h1);

        // interrupt beats a same-cycle csrrw
        csr_wr(12'h340, 32'h0000_AAAA);
        csr_wr(12'h300, 32'h0000_0008);
        irq = 4'b0010; tick();
        int_window = 1; w_en = 1; op = 3'b001; csr_addr = 12'h340; din = 32'h5555;
        tick();
        int_window = 0; w_en = 0; op = 3'b000; irq = 0;
        chk("irqwr_taken", {31'b0, trap_taken}, 1);
        chk("irqwr_vec", trap_vector, 32'h144);
        rd("irqwr_mscratch", 12'h340, 32'h0000_AAAA);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
